// File: rtl/bram_sp_ctrl.sv
// bram_sp_ctrl: valid/ready request front end for a single-port BRAM.
// Requests pass straight through to the BRAM in the cycle they are accepted.
// Each accepted access occupies one response-FIFO credit until it is popped.
// A read takes its data from the BRAM one cycle later. A write receives a
// zero-data ack in the same slot, so responses always come back in order.
// The lane width is BRAM_DATA_WIDTH / STRB_WIDTH. The data width must
// therefore be a multiple of the strobe count.

module bram_sp_ctrl #(
  parameter int BRAM_DATA_WIDTH = 80,
  parameter int BRAM_ADDR_WIDTH = 8,
  parameter int STRB_WIDTH      = 8,
  parameter int RSP_DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [STRB_WIDTH-1:0]      req_strb_i,
  input  logic [BRAM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [BRAM_DATA_WIDTH-1:0] req_wdata_i,

  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic                       rsp_we_o,
  output logic [BRAM_DATA_WIDTH-1:0] rsp_rdata_o,

  output logic                       bram_we_o,
  output logic [STRB_WIDTH-1:0]      bram_write_strobe_o,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_o,
  output logic [BRAM_DATA_WIDTH-1:0] bram_din_o,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_dout_i
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(RSP_DEPTH - 1);

  // Control state
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic             inflight_q, inflight_d;
  logic             inflightWe_q, inflightWe_d;

  // Response storage (data path only, no reset needed)
  logic [BRAM_DATA_WIDTH-1:0] rspData_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]       rspWe_q;

  logic                       acc;
  logic                       push;
  logic                       pop;
  logic [CNT_W:0]             creditsUsed;
  logic [BRAM_DATA_WIDTH-1:0] pushData;

  // Pointers wrap explicitly, so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // The credit check uses registered state only. A slot is reserved for
  // every queued response and for the access still waiting on the BRAM.
  assign creditsUsed = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign req_ready_o = rst_ni & (creditsUsed < DEPTH_C);
  assign acc         = req_valid_i & req_ready_o;

  assign bram_addr_o         = req_addr_i;
  assign bram_din_o          = req_wdata_i;
  assign bram_write_strobe_o = req_strb_i;
  assign bram_we_o           = acc & req_we_i;

  // The access issued last cycle produces its response this cycle.
  // Write acks carry zero data rather than whatever the BRAM drives.
  assign push     = inflight_q;
  assign pushData = inflightWe_q ? '0 : bram_dout_i;

  assign rsp_valid_o = (count_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? rspData_q[headPtr_q] : '0;
  assign rsp_we_o    = rsp_valid_o & rspWe_q[headPtr_q];

  // Next-state logic for the in-flight flag, the FIFO pointers and the
  // occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_comb begin
    inflight_d   = acc;
    inflightWe_d = acc & req_we_i;
    headPtr_d    = headPtr_q;
    tailPtr_d    = tailPtr_q;
    count_d      = count_q;

    if (push) tailPtr_d = nextPtr(tailPtr_q);
    if (pop)  headPtr_d = nextPtr(headPtr_q);

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers. Reset drops the in-flight access and all queued
  // responses at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      headPtr_q    <= '0;
      tailPtr_q    <= '0;
      inflight_q   <= 1'b0;
      inflightWe_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      headPtr_q    <= headPtr_d;
      tailPtr_q    <= tailPtr_d;
      inflight_q   <= inflight_d;
      inflightWe_q <= inflightWe_d;
    end
  end

  // Response storage is written at the tail slot. Nothing downstream
  // reads an entry until the count covers it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rspData_q[tailPtr_q] <= pushData;
      rspWe_q[tailPtr_q]   <= inflightWe_q;
    end
  end

endmodule
